// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Data-hazard resolution for a classic 5-stage in-order pipeline. The block
// keeps its own shadow copy of the register indices and write/load flags of
// the instructions in EX, MEM and WB, and from that state plus the decode
// stage inputs produces:
//   - ALU operand forwarding selects (EX/MEM first, then MEM/WB),
//   - a one-cycle fetch/decode stall on a load-use dependency,
//   - decode/execute flushes when a control transfer resolves taken.
//
// Optional build macro: HAZARD_STATS_EN
//   When defined, adds saturating 16-bit stall and flush event counters
//   (ports stallCount / flushCount). When undefined, those ports and their
//   logic do not exist.
//
// Ports
//   clk             in   1  rising-edge clock
//   reset           in   1  synchronous active-high reset
//   rs1Decode       in   5  decode-stage source register 1
//   rs2Decode       in   5  decode-stage source register 2
//   rdDecode        in   5  decode-stage destination register
//   regWriteDecode  in   1  decode instruction writes rd
//   memReadDecode   in   1  decode instruction is a load
//   validDecode     in   1  decode holds a real instruction
//   branchTaken     in   1  execute-stage control transfer resolved taken
//   forwardSelect1  out  2  ALU operand 1 source: 00 RF, 01 EX/MEM, 10 MEM/WB
//   forwardSelect2  out  2  ALU operand 2 source: 00 RF, 01 EX/MEM, 10 MEM/WB
//   stallFetch      out  1  hold the PC
//   stallDecode     out  1  hold the IF/ID register
//   flushDecode     out  1  bubble the IF/ID register
//   flushExecute    out  1  bubble the ID/EX register
//   stallCount      out 16  (HAZARD_STATS_EN) cycles with stallDecode = 1
//   flushCount      out 16  (HAZARD_STATS_EN) cycles with flushExecute = 1
//
// Same-cycle write-back-to-decode hazards are not handled here; the register
// file is write-first and covers them.
// -----------------------------------------------------------------------------
module hazard_forward_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs1Decode,
    input  logic [4:0] rs2Decode,
    input  logic [4:0] rdDecode,
    input  logic       regWriteDecode,
    input  logic       memReadDecode,
    input  logic       validDecode,
    input  logic       branchTaken,
    output logic [1:0] forwardSelect1,
    output logic [1:0] forwardSelect2,
    output logic       stallFetch,
    output logic       stallDecode,
    output logic       flushDecode,
    output logic       flushExecute
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stallCount,
    output logic [15:0] flushCount
`endif
);

    // Forwarding source encodings; 2'b11 is never produced.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // Shadow pipeline state
    logic [4:0] ex_rs1_r;
    logic [4:0] ex_rs2_r;
    logic [4:0] ex_rd_r;
    logic       ex_reg_write_r;
    logic       ex_mem_read_r;
    logic [4:0] mem_rd_r;
    logic       mem_reg_write_r;
    logic [4:0] wb_rd_r;
    logic       wb_reg_write_r;

    logic       load_use_s;
    logic       bubble_s;

    // Operand source for one EX source register. The nearer producer (MEM)
    // wins over WB, and x0 is never forwarded because it is hard-wired zero.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] m_rd,
        input logic       m_rw,
        input logic [4:0] w_rd,
        input logic       w_rw
    );
        logic [1:0] sel;
        if (m_rw && (m_rd != 5'd0) && (m_rd == src)) begin
            sel = FWD_MEM;
        end else if (w_rw && (w_rd != 5'd0) && (w_rd == src)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    // Load-use detection and EX bubble decision. The rs2 compare is made even
    // for instructions that ignore rs2: a rare spurious stall is cheaper than
    // decoding operand usage here.
    always_comb begin
        load_use_s = 1'b0;
        if (ex_mem_read_r && (ex_rd_r != 5'd0) && validDecode &&
            ((ex_rd_r == rs1Decode) || (ex_rd_r == rs2Decode))) begin
            load_use_s = 1'b1;
        end else begin
            load_use_s = 1'b0;
        end
        bubble_s = load_use_s | branchTaken | ~validDecode;
    end

    // Forward, stall and flush outputs; a taken branch overrides the stall
    // because the dependent instruction is being discarded anyway.
    always_comb begin
        forwardSelect1 = FWD_RF;
        forwardSelect2 = FWD_RF;
        stallFetch     = 1'b0;
        stallDecode    = 1'b0;
        flushDecode    = 1'b0;
        flushExecute   = 1'b0;
        forwardSelect1 = fwd_sel(ex_rs1_r, mem_rd_r, mem_reg_write_r, wb_rd_r, wb_reg_write_r);
        forwardSelect2 = fwd_sel(ex_rs2_r, mem_rd_r, mem_reg_write_r, wb_rd_r, wb_reg_write_r);
        stallFetch     = load_use_s & ~branchTaken;
        stallDecode    = load_use_s & ~branchTaken;
        flushDecode    = branchTaken;
        flushExecute   = branchTaken;
    end

    // Shadow state advance: EX takes decode or a bubble, MEM and WB always shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs1_r        <= 5'd0;
            ex_rs2_r        <= 5'd0;
            ex_rd_r         <= 5'd0;
            ex_reg_write_r  <= 1'b0;
            ex_mem_read_r   <= 1'b0;
            mem_rd_r        <= 5'd0;
            mem_reg_write_r <= 1'b0;
            wb_rd_r         <= 5'd0;
            wb_reg_write_r  <= 1'b0;
        end else begin
            if (bubble_s) begin
                ex_rs1_r       <= 5'd0;
                ex_rs2_r       <= 5'd0;
                ex_rd_r        <= 5'd0;
                ex_reg_write_r <= 1'b0;
                ex_mem_read_r  <= 1'b0;
            end else begin
                ex_rs1_r       <= rs1Decode;
                ex_rs2_r       <= rs2Decode;
                ex_rd_r        <= rdDecode;
                ex_reg_write_r <= regWriteDecode & validDecode;
                ex_mem_read_r  <= memReadDecode & validDecode;
            end
            mem_rd_r        <= ex_rd_r;
            mem_reg_write_r <= ex_reg_write_r;
            wb_rd_r         <= mem_rd_r;
            wb_reg_write_r  <= mem_reg_write_r;
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating stall/flush event counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            stallCount <= 16'd0;
            flushCount <= 16'd0;
        end else begin
            if (stallDecode && (stallCount != 16'hFFFF)) begin
                stallCount <= stallCount + 16'd1;
            end else begin
                stallCount <= stallCount;
            end
            if (flushExecute && (flushCount != 16'hFFFF)) begin
                flushCount <= flushCount + 16'd1;
            end else begin
                flushCount <= flushCount;
            end
        end
    end
`endif

endmodule
